// File: rtl/trace_pkg.sv
// Shared types and widths for the bird-trail scheduler.
// Coordinates are 11 bits; comparisons widen to 12 so slot+size never wraps.
package trace_pkg;

  localparam int COORD_W = 11;
  localparam int CMP_W   = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RECORD = 2'd2,
    HOLD   = 2'd3
  } trace_state_t;

endpackage

// File: rtl/trace_dot_hit.sv
// Combinational point-in-square test for one trace slot.
// Slot coordinates are signed, pixel coordinates unsigned; both widen to CMP_W.
import trace_pkg::*;

module trace_dot_hit #(
  parameter int DOT_SIZE = 4
) (
  input  logic               valid_i,
  input  logic [COORD_W-1:0] slot_x_i,
  input  logic [COORD_W-1:0] slot_y_i,
  input  logic [COORD_W-1:0] pixel_x_i,
  input  logic [COORD_W-1:0] pixel_y_i,
  output logic               hit_o
);

  localparam logic signed [CMP_W-1:0] SIZE_S = CMP_W'(DOT_SIZE);

  logic signed [CMP_W-1:0] slot_x_s;
  logic signed [CMP_W-1:0] slot_y_s;
  logic signed [CMP_W-1:0] pix_x_s;
  logic signed [CMP_W-1:0] pix_y_s;

  assign slot_x_s = {slot_x_i[COORD_W-1], slot_x_i};
  assign slot_y_s = {slot_y_i[COORD_W-1], slot_y_i};
  assign pix_x_s  = {1'b0, pixel_x_i};
  assign pix_y_s  = {1'b0, pixel_y_i};

  assign hit_o = valid_i
              && (pix_x_s >= slot_x_s) && (pix_x_s < slot_x_s + SIZE_S)
              && (pix_y_s >= slot_y_s) && (pix_y_s < slot_y_s + SIZE_S);

endmodule

// File: rtl/trace_scheduler.sv
// Owns the ring of trace-dot slots: clears it on launch, samples the bird
// position every SAMPLE_FRAMES frames in flight, freezes on impact, draws dots.
import trace_pkg::*;

module trace_scheduler #(
  parameter int NUM_DOTS      = 8,
  parameter int SAMPLE_FRAMES = 4,
  parameter int DOT_SIZE      = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               launch,
  input  logic               inFlight,
  input  logic               collision,
  input  logic [COORD_W-1:0] birdX,
  input  logic [COORD_W-1:0] birdY,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  output logic               traceDR,
  output logic [4:0]         dotCount,
  output logic               recording
);

  localparam int PTR_W = (NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1;
  localparam int CNT_W = (SAMPLE_FRAMES > 1) ? $clog2(SAMPLE_FRAMES) : 1;

  trace_state_t         state_q, state_d;
  logic [NUM_DOTS-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     clr_idx_q, clr_idx_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [4:0]           dot_count_q, dot_count_d;
  logic                 recording_q;
  logic                 trace_dr_q;
  logic                 sample_en;

  logic [COORD_W-1:0]   slot_x_q [NUM_DOTS];
  logic [COORD_W-1:0]   slot_y_q [NUM_DOTS];

  logic [NUM_DOTS-1:0]  dot_live;
  logic [NUM_DOTS-1:0]  dot_hit;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    wr_ptr_d    = wr_ptr_q;
    clr_idx_d   = clr_idx_q;
    frame_cnt_d = frame_cnt_q;
    dot_count_d = dot_count_q;
    sample_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        valid_d[clr_idx_q] = 1'b0;
        if (launch) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == PTR_W'(NUM_DOTS - 1)) begin
          state_d     = RECORD;
          wr_ptr_d    = '0;
          frame_cnt_d = '0;
          dot_count_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      RECORD: begin
        if (launch) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end else if (collision || !inFlight) begin
          state_d = HOLD;
        end else if (startOfFrame) begin
          if (frame_cnt_q == CNT_W'(SAMPLE_FRAMES - 1)) begin
            sample_en         = 1'b1;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
            frame_cnt_d       = '0;
            if (dot_count_q != 5'(NUM_DOTS)) begin
              dot_count_d = dot_count_q + 5'd1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (launch) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      wr_ptr_q    <= '0;
      clr_idx_q   <= '0;
      frame_cnt_q <= '0;
      dot_count_q <= '0;
      recording_q <= 1'b0;
      trace_dr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      wr_ptr_q    <= wr_ptr_d;
      clr_idx_q   <= clr_idx_d;
      frame_cnt_q <= frame_cnt_d;
      dot_count_q <= dot_count_d;
      recording_q <= (state_d == RECORD);
      trace_dr_q  <= |dot_hit;
    end
  end

  // Slot coordinates need no reset: valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (sample_en) begin
      slot_x_q[wr_ptr_q] <= birdX;
      slot_y_q[wr_ptr_q] <= birdY;
    end
  end

  // The slot being cleared this cycle is already suppressed from drawing.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DOTS; gi++) begin : g_dot
      assign dot_live[gi] = valid_q[gi]
                         && !((state_q == CLEAR) && (clr_idx_q == PTR_W'(gi)));
      trace_dot_hit #(
        .DOT_SIZE (DOT_SIZE)
      ) u_hit (
        .valid_i   (dot_live[gi]),
        .slot_x_i  (slot_x_q[gi]),
        .slot_y_i  (slot_y_q[gi]),
        .pixel_x_i (pixelX),
        .pixel_y_i (pixelY),
        .hit_o     (dot_hit[gi])
      );
    end
  endgenerate

  assign traceDR   = trace_dr_q;
  assign dotCount  = dot_count_q;
  assign recording = recording_q;

endmodule

// File: tb/tb_trace_scheduler.sv
// Directed plus randomized bench for trace_scheduler with a behavioural
// model of the trail (sample list, clear progress, mode) checked every clock.
module tb_trace_scheduler;

  localparam int N  = 8;
  localparam int SF = 4;
  localparam int DS = 4;

  logic        clk = 1'b0;
  logic        resetN, startOfFrame, launch, inFlight, collision;
  logic [10:0] birdX, birdY, pixelX, pixelY;
  logic        traceDR;
  logic [4:0]  dotCount;
  logic        recording;

  always #5 clk = ~clk;

  trace_scheduler #(
    .NUM_DOTS      (N),
    .SAMPLE_FRAMES (SF),
    .DOT_SIZE      (DS)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .launch       (launch),
    .inFlight     (inFlight),
    .collision    (collision),
    .birdX        (birdX),
    .birdY        (birdY),
    .pixelX       (pixelX),
    .pixelY       (pixelY),
    .traceDR      (traceDR),
    .dotCount     (dotCount),
    .recording    (recording)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: mode 0=idle 1=clearing 2=recording 3=holding
  int m_mode, m_clear_n, m_frames, m_samples;
  int m_x [N];
  int m_y [N];
  bit m_valid [N];

  function automatic bit model_hit(int px, int py);
    bit h = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && !(m_mode == 1 && m_clear_n == i) &&
          px >= m_x[i] && px < m_x[i] + DS && py >= m_y[i] && py < m_y[i] + DS)
        h = 1'b1;
    end
    return h;
  endfunction

  function automatic int model_count();
    return (m_samples > N) ? N : m_samples;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int s;
    if (resetN) begin
      m_mode = 0; m_clear_n = 0; m_frames = 0; m_samples = 0;
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    end else begin
      case (m_mode)
        0: if (launch) begin m_mode = 1; m_clear_n = 0; end
        1: begin
          m_valid[m_clear_n] = 1'b0;
          if (launch) m_clear_n = 0;
          else if (m_clear_n == N - 1) begin
            m_mode = 2; m_frames = 0; m_samples = 0;
          end else m_clear_n++;
        end
        2: begin
          if (launch) begin m_mode = 1; m_clear_n = 0; end
          else if (collision || !inFlight) m_mode = 3;
          else if (startOfFrame) begin
            m_frames++;
            if (m_frames % SF == 0) begin
              s = m_samples % N;
              m_x[s] = int'($signed(birdX));
              m_y[s] = int'($signed(birdY));
              m_valid[s] = 1'b1;
              m_samples++;
            end
          end
        end
        default: if (launch) begin m_mode = 1; m_clear_n = 0; end
      endcase
    end
  endtask

  // One clock: predict, advance, compare all outputs, then drop pulses.
  task automatic tick();
    bit exp_tr;
    exp_tr = resetN ? 1'b0 : model_hit(int'(pixelX), int'(pixelY));
    @(posedge clk);
    model_edge();
    #1;
    chk("traceDR", 32'(traceDR), 32'(exp_tr));
    chk("dotCount", 32'(dotCount), 32'(model_count()));
    chk("recording", 32'(recording), 32'(m_mode == 2));
    launch = 1'b0;
    startOfFrame = 1'b0;
  endtask

  task automatic set_pixel(input int px, input int py);
    pixelX = 11'((px < 0) ? 0 : px);
    pixelY = 11'((py < 0) ? 0 : py);
  endtask

  task automatic rand_pixel();
    int i;
    if ($urandom_range(0, 3) != 0) begin
      i = int'($urandom_range(0, N - 1));
      set_pixel(m_x[i] + int'($urandom_range(0, 7)) - 2,
                m_y[i] + int'($urandom_range(0, 7)) - 2);
    end else begin
      set_pixel(int'($urandom_range(0, 700)), int'($urandom_range(0, 500)));
    end
  endtask

  int n, saved;
  int old_x [N];
  int old_y [N];

  initial begin
    for (int i = 0; i < N; i++) begin m_x[i] = 0; m_y[i] = 0; m_valid[i] = 1'b0; end
    m_mode = 0; m_clear_n = 0; m_frames = 0; m_samples = 0;
    resetN = 1'b1; startOfFrame = 1'b0; launch = 1'b0; inFlight = 1'b1;
    collision = 1'b0; birdX = 11'd100; birdY = 11'd200;
    pixelX = 11'd0; pixelY = 11'd0;

    // 1. reset then launch; recording after exactly N clocks
    tick(); tick();
    chk("reset_dr", 32'(traceDR), 32'd0);
    chk("reset_cnt", 32'(dotCount), 32'd0);
    resetN = 1'b0;
    tick();
    launch = 1'b1;
    tick();
    n = 0;
    while (!recording && n < 20) begin rand_pixel(); tick(); n++; end
    chk("launch_latency", 32'(n), 32'd8);

    // 2. sampling cadence
    for (int f = 0; f < SF; f++) begin
      startOfFrame = 1'b1; tick(); tick(); tick();
    end
    chk("cadence_cnt", 32'(dotCount), 32'd1);
    set_pixel(101, 202); tick();
    chk("cadence_hit", 32'(traceDR), 32'd1);
    set_pixel(104, 200); tick();
    chk("cadence_edge", 32'(traceDR), 32'd0);

    // 3. ring wrap with birdX = frame index
    for (int f = 0; f < 40; f++) begin
      birdX = 11'(f); birdY = 11'($urandom_range(0, 400));
      startOfFrame = 1'b1; rand_pixel(); tick();
      rand_pixel(); tick();
    end
    chk("wrap_cnt", 32'(dotCount), 32'd8);
    set_pixel(101, 202); tick();
    chk("wrap_old_gone", 32'(traceDR), 32'd0);
    set_pixel(0, m_y[0]); tick();
    chk("wrap_x0", 32'(traceDR), 32'd0);
    set_pixel(32, m_y[0] + 1); tick();
    chk("wrap_slot0", 32'(traceDR), 32'd1);

    // 4. collision on the sampling frame
    n = 0;
    while ((m_frames + 1) % SF != 0 && n < SF) begin startOfFrame = 1'b1; tick(); n++; end
    saved = model_count();
    startOfFrame = 1'b1; collision = 1'b1; tick();
    collision = 1'b0;
    chk("tie_rec", 32'(recording), 32'd0);
    chk("tie_cnt", 32'(dotCount), 32'(saved));
    set_pixel(m_x[3] + 2, m_y[3] + 3); tick();
    chk("hold_draw", 32'(traceDR), 32'd1);
    for (int f = 0; f < 6; f++) begin
      inFlight = f[0]; startOfFrame = 1'b1; rand_pixel(); tick();
    end
    inFlight = 1'b1; tick();
    chk("hold_cnt", 32'(dotCount), 32'(saved));
    chk("hold_rec", 32'(recording), 32'd0);

    // 5. relaunch from HOLD
    for (int i = 0; i < N; i++) begin old_x[i] = m_x[i]; old_y[i] = m_y[i]; end
    launch = 1'b1; tick();
    for (int k = 0; k < N; k++) begin set_pixel(old_x[k] + 1, old_y[k] + 1); tick(); end
    chk("relaunch_rec", 32'(recording), 32'd1);
    chk("relaunch_cnt", 32'(dotCount), 32'd0);
    for (int k = 0; k < N; k++) begin
      set_pixel(old_x[k] + 1, old_y[k] + 1); tick();
      chk("relaunch_dr", 32'(traceDR), 32'd0);
    end

    // 6A. reset while recording
    birdX = 11'd300; birdY = 11'd50;
    for (int f = 0; f < SF; f++) begin startOfFrame = 1'b1; tick(); end
    set_pixel(301, 51); tick();
    chk("pre_reset_dr", 32'(traceDR), 32'd1);
    resetN = 1'b1; tick();
    chk("rst_dr", 32'(traceDR), 32'd0);
    chk("rst_cnt", 32'(dotCount), 32'd0);
    chk("rst_rec", 32'(recording), 32'd0);
    resetN = 1'b0; tick();

    // 6B. relaunch mid-clear at clrIdx=5
    launch = 1'b1; tick();
    for (int k = 0; k < 5; k++) tick();
    launch = 1'b1; tick();
    n = 0;
    while (!recording && n < 20) begin tick(); n++; end
    chk("reclear_latency", 32'(n), 32'd8);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      resetN       = ($urandom_range(0, 249) == 0);
      launch       = ($urandom_range(0, 59) == 0);
      startOfFrame = ($urandom_range(0, 3) == 0);
      collision    = ($urandom_range(0, 49) == 0);
      inFlight     = ($urandom_range(0, 24) != 0);
      birdX        = 11'(int'($urandom_range(0, 730)) - 30);
      birdY        = 11'(int'($urandom_range(0, 530)) - 30);
      rand_pixel();
      tick();
    end
    resetN = 1'b0;
    collision = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
